// File: rtl/ps2_kbd_cmd_sched_if.sv
// Bundle between the command scheduler, its host, the lock-key source and ps2_keyboard.
// The scheduler takes master; the surrounding logic, or a bench, takes slave.
interface ps2_kbd_cmd_sched_if;
  logic       host_cmd_valid;
  logic       host_cmd_ready;
  logic [7:0] host_cmd_b0;
  logic [7:0] host_cmd_b1;
  logic       host_cmd_len2;
  logic [2:0] lock_toggle;
  logic [2:0] led_state;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_write_ack;
  logic       tx_no_ack;
  logic [7:0] rx_code;
  logic       rx_valid;
  logic       busy;
  logic       cmd_done;
  logic       cmd_err;

  modport master (
    input  host_cmd_valid, host_cmd_b0, host_cmd_b1, host_cmd_len2, lock_toggle,
    input  tx_write_ack, tx_no_ack, rx_code, rx_valid,
    output host_cmd_ready, led_state, tx_data, tx_write, busy, cmd_done, cmd_err
  );

  modport slave (
    output host_cmd_valid, host_cmd_b0, host_cmd_b1, host_cmd_len2, lock_toggle,
    output tx_write_ack, tx_no_ack, rx_code, rx_valid,
    input  host_cmd_ready, led_state, tx_data, tx_write, busy, cmd_done, cmd_err
  );
endinterface

// File: rtl/ps2_kbd_cmd_sched.sv
// PS/2 host-to-keyboard command scheduler: LED updates beat host commands, each byte waits for 0xFA, resends/times out; host is held off while busy.
// PS2_CMD_BOOT_INIT_EN: after reset send 0xFF, wait for 0xAA, then send 0xED 0x00 before accepting any request.
module ps2_kbd_cmd_sched #(
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TW          = 22
) (
  input  logic               clk,
  input  logic               rst,
  ps2_kbd_cmd_sched_if.master bus
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0] KBD_ACK    = 8'hFA;
  localparam logic [7:0] KBD_RESEND = 8'hFE;
  localparam logic [7:0] KBD_BAT_OK = 8'hAA;
  localparam logic [7:0] KBD_SETLED = 8'hED;

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_WACK, WAIT_RESP, WAIT_BAT, DONE, ERR
  } state_e;

`ifdef PS2_CMD_BOOT_INIT_EN
  localparam state_e     RST_STATE = SEND;
  localparam logic [7:0] RST_B0    = 8'hFF;
  localparam logic       RST_BOOT  = 1'b1;
`else
  localparam state_e     RST_STATE = IDLE;
  localparam logic [7:0] RST_B0    = 8'h00;
  localparam logic       RST_BOOT  = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [7:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic            len2_q, len2_d;
  logic            sel_q, sel_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [2:0]      led_q, led_d;
  logic            boot_q, boot_d;
  logic            tx_write_q, tx_write_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [TW-1:0]   cnt_inc;
  logic            timeout;
  logic            can_retry;
  logic            do_retry;
  logic            rx_ack;
  logic            rx_resend;

  assign cnt_inc   = cnt_q + TW'(1);
  assign timeout   = (cnt_inc == TW'(TIMEOUT_CYC - 1));
  assign can_retry = (retry_q < RW'(MAX_RETRY));
  assign rx_ack    = bus.rx_valid && (bus.rx_code == KBD_ACK);
  assign rx_resend = bus.rx_valid && (bus.rx_code == KBD_RESEND);

  always_comb begin
    state_d    = state_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    len2_d     = len2_q;
    sel_d      = sel_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q | (|bus.lock_toggle);
    led_d      = led_q ^ bus.lock_toggle;
    boot_d     = boot_q;
    tx_write_d = 1'b0;
    tx_data_d  = tx_data_q;
    do_retry   = 1'b0;

    case (state_q)
      IDLE: begin
        // Snapshot uses the registered LED state, so a toggle landing on the
        // grant cycle is left for a follow-up 0xED.
        if (pend_q) begin
          b0_d    = KBD_SETLED;
          b1_d    = {5'b0, led_q};
          len2_d  = 1'b1;
          sel_d   = 1'b0;
          retry_d = '0;
          pend_d  = |bus.lock_toggle;
          state_d = SEND;
        end else if (bus.host_cmd_valid && bus.host_cmd_ready) begin
          b0_d    = bus.host_cmd_b0;
          b1_d    = bus.host_cmd_b1;
          len2_d  = bus.host_cmd_len2;
          sel_d   = 1'b0;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_data_d  = sel_q ? b1_q : b0_q;
        tx_write_d = 1'b1;
        state_d    = WAIT_WACK;
      end
      WAIT_WACK: begin
        if (bus.tx_write_ack) begin
          cnt_d   = '0;
          state_d = WAIT_RESP;
        end else if (bus.tx_no_ack) begin
          do_retry = 1'b1;
        end else begin
          tx_write_d = 1'b1;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_inc;
        if (rx_ack) begin
          if (len2_q && !sel_q) begin
            sel_d   = 1'b1;
            retry_d = '0;
            state_d = SEND;
          end else if (boot_q) begin
            cnt_d   = '0;
            state_d = WAIT_BAT;
          end else begin
            state_d = DONE;
          end
        end else if (rx_resend) begin
          do_retry = 1'b1;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      WAIT_BAT: begin
        cnt_d = cnt_inc;
        if (bus.rx_valid && (bus.rx_code == KBD_BAT_OK)) begin
          b0_d    = KBD_SETLED;
          b1_d    = 8'h00;
          len2_d  = 1'b1;
          sel_d   = 1'b0;
          retry_d = '0;
          boot_d  = 1'b0;
          state_d = SEND;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        boot_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_retry) begin
      if (can_retry) begin
        retry_d = retry_q + RW'(1);
        state_d = SEND;
      end else begin
        state_d = ERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      b0_q       <= RST_B0;
      b1_q       <= 8'h00;
      len2_q     <= 1'b0;
      sel_q      <= 1'b0;
      retry_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      led_q      <= 3'b000;
      boot_q     <= RST_BOOT;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      len2_q     <= len2_d;
      sel_q      <= sel_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      led_q      <= led_d;
      boot_q     <= boot_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // A toggle arriving this cycle already blocks the host so the LED update wins.
  assign bus.host_cmd_ready = !rst && (state_q == IDLE) && !pend_q && (bus.lock_toggle == 3'b000);
  assign bus.busy           = !rst && (state_q != IDLE);
  assign bus.cmd_done       = !rst && (state_q == DONE);
  assign bus.cmd_err        = !rst && (state_q == ERR);
  assign bus.led_state      = led_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_write       = tx_write_q;

endmodule
